// File: rtl/bitcmp_serial_arbiter.sv
// bitcmp_serial_arbiter: round-robin scheduler running MSB-first compares on a shared 1-bit comparator slice
module bitcmp_serial_arbiter #(
    parameter int WIDTH      = 8,
    parameter int EARLY_EXIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic             rsp_lt,
    output logic             rsp_eq,
    output logic             rsp_gt,
    output logic             rsp_err,
    output logic             busy,
    output logic             cmp_a,
    output logic             cmp_b,
    output logic             cmp_l,
    output logic             cmp_e,
    output logic             cmp_g,
    input  logic             cmp_L,
    input  logic             cmp_E,
    input  logic             cmp_G
);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nx;
    logic             rr_ptr, id_r, l_r, e_r, g_r, err_r;
    logic [WIDTH-1:0] a_r, b_r;
    logic [IW-1:0]    idx;
    logic             gnt0, gnt1, onehot, last;

    assign onehot     = ({cmp_L, cmp_E, cmp_G} == 3'b100) || ({cmp_L, cmp_E, cmp_G} == 3'b010) ||
                        ({cmp_L, cmp_E, cmp_G} == 3'b001);
    assign busy       = state != IDLE;
    assign rsp_valid  = state == DONE;
    assign rsp_id     = rsp_valid && id_r;
    assign rsp_lt     = rsp_valid && l_r;
    assign rsp_eq     = rsp_valid && e_r;
    assign rsp_gt     = rsp_valid && g_r;
    assign rsp_err    = err_r;
    assign cmp_a      = a_r[idx];
    assign cmp_b      = b_r[idx];
    assign cmp_l      = l_r;
    assign cmp_e      = e_r;
    assign cmp_g      = g_r;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Grant selection, single-cycle ready pulses and next-state decode
    always_comb begin
        gnt0       = req0_valid && (!req1_valid || !rr_ptr);
        gnt1       = req1_valid && (!req0_valid || rr_ptr);
        last       = (idx == '0) || (EARLY_EXIT != 0 && !cmp_E) || !onehot;
        req0_ready = rst_n && state == IDLE && gnt0;
        req1_ready = rst_n && state == IDLE && gnt1;
        state_nx   = state;
        case (state)
            IDLE:    state_nx = (gnt0 || gnt1) ? RUN : IDLE;
            RUN:     state_nx = last ? DONE : RUN;
            DONE:    state_nx = rsp_ready ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end

    // Operand latch on grant, cascade capture and bit walk while running
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= 1'b0;
            id_r   <= 1'b0;
            a_r    <= '0;
            b_r    <= '0;
            idx    <= '0;
            l_r    <= 1'b0;
            e_r    <= 1'b1;
            g_r    <= 1'b0;
            err_r  <= 1'b0;
        end else if (state == IDLE && (gnt0 || gnt1)) begin
            a_r    <= gnt1 ? req1_a : req0_a;
            b_r    <= gnt1 ? req1_b : req0_b;
            id_r   <= gnt1;
            rr_ptr <= !gnt1;
            idx    <= IW'(WIDTH - 1);
            l_r    <= 1'b0;
            e_r    <= 1'b1;
            g_r    <= 1'b0;
        end else if (state == RUN) begin
            l_r    <= cmp_L;
            e_r    <= cmp_E;
            g_r    <= cmp_G;
            err_r  <= !onehot;
            idx    <= last ? idx : idx - IW'(1);
        end else if (state == DONE && rsp_ready) begin
            err_r  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_bitcmp_serial_arbiter.sv
// tb_bitcmp_serial_arbiter: directed scenarios against behavioural comparator slices
module tb_bitcmp_serial_arbiter;
    logic       clk, rst_n, rr, inst, fault;
    logic       r0v, r1v, x0v, x1v;
    logic [7:0] r0a, r0b, r1a, r1b, x0a, x0b, x1a, x1b;
    logic       r0r, r1r, rv, rid, rlt, req, rgt, rerr, busy, ca, cb, cl, ce, cg, sL, sE, sG;
    logic       xr0r, xr1r, xrv, xrid, xlt, xeq, xgt, xerr, xbusy, xca, xcb, xcl, xce, xcg, xsL, xsE, xsG;
    logic       o_rv, o_busy, o_r0r, o_r1r, o_lt, o_eq, o_gt, o_id, o_err;
    int         errors, checks, run_cnt, lat, runs;

    bitcmp_serial_arbiter #(.WIDTH(8), .EARLY_EXIT(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(r0v), .req0_ready(r0r), .req0_a(r0a), .req0_b(r0b),
        .req1_valid(r1v), .req1_ready(r1r), .req1_a(r1a), .req1_b(r1b),
        .rsp_valid(rv), .rsp_ready(rr), .rsp_id(rid), .rsp_lt(rlt), .rsp_eq(req), .rsp_gt(rgt),
        .rsp_err(rerr), .busy(busy), .cmp_a(ca), .cmp_b(cb), .cmp_l(cl), .cmp_e(ce), .cmp_g(cg),
        .cmp_L(sL), .cmp_E(sE), .cmp_G(sG)
    );

    bitcmp_serial_arbiter #(.WIDTH(8), .EARLY_EXIT(0)) dut_full (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(x0v), .req0_ready(xr0r), .req0_a(x0a), .req0_b(x0b),
        .req1_valid(x1v), .req1_ready(xr1r), .req1_a(x1a), .req1_b(x1b),
        .rsp_valid(xrv), .rsp_ready(rr), .rsp_id(xrid), .rsp_lt(xlt), .rsp_eq(xeq), .rsp_gt(xgt),
        .rsp_err(xerr), .busy(xbusy), .cmp_a(xca), .cmp_b(xcb), .cmp_l(xcl), .cmp_e(xce), .cmp_g(xcg),
        .cmp_L(xsL), .cmp_E(xsE), .cmp_G(xsG)
    );

    assign o_rv   = inst ? xrv   : rv;
    assign o_busy = inst ? xbusy : busy;
    assign o_r0r  = inst ? xr0r  : r0r;
    assign o_r1r  = inst ? xr1r  : r1r;
    assign o_lt   = inst ? xlt   : rlt;
    assign o_eq   = inst ? xeq   : req;
    assign o_gt   = inst ? xgt   : rgt;
    assign o_id   = inst ? xrid  : rid;
    assign o_err  = inst ? xerr  : rerr;

    always #5 clk = ~clk;

    // Cascaded 1-bit comparator slice; the fault forces L=E=1 on the third run cycle (bit 5)
    always_comb begin
        sE = ce && (ca == cb);
        sL = cl || (ce && !ca && cb);
        sG = cg || (ce && ca && !cb);
        if (fault && run_cnt == 2) begin
            sL = 1'b1;
            sE = 1'b1;
            sG = 1'b0;
        end
    end

    always_comb begin
        xsE = xce && (xca == xcb);
        xsL = xcl || (xce && !xca && xcb);
        xsG = xcg || (xce && xca && !xcb);
    end

    always @(posedge clk) run_cnt <= (busy && !rv) ? run_cnt + 1 : 0;

    task automatic do_reset();
        rst_n = 1'b0;
        {r0v, r1v, x0v, x1v, rr} = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic hs();
        rr = 1'b1;
        @(posedge clk);
        #1;
        rr = 1'b0;
    endtask

    task automatic run_op(input logic id, input logic [7:0] a, input logic [7:0] b, output int l, output int r);
        int n;
        @(negedge clk);
        if (inst) begin
            if (id) begin x1v = 1'b1; x1a = a; x1b = b; end else begin x0v = 1'b1; x0a = a; x0b = b; end
        end else begin
            if (id) begin r1v = 1'b1; r1a = a; r1b = b; end else begin r0v = 1'b1; r0a = a; r0b = b; end
        end
        n = 0;
        #1;
        while (!(id ? o_r1r : o_r0r) && n < 40) begin @(negedge clk); #1; n++; end
        @(posedge clk);
        #1;
        {r0v, r1v, x0v, x1v} = '0;
        r0a = ~a; r1a = ~a; x0a = ~a; x1a = ~a;
        l = 0;
        r = 0;
        do begin
            @(negedge clk);
            l++;
            if (!o_rv && o_busy) r++;
        end while (!o_rv && l < 40);
        checks++; if (o_rv !== 1'b1) begin errors++; $display("FAIL rsp_timeout rsp_valid=%b required=1", o_rv); end
    endtask

    task automatic test_reset();
        r0v = 1'b1;
        r1v = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (rv !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", rv); end
        checks++; if ({r0r, r1r} !== 2'b00) begin errors++; $display("FAIL reset_ready got=%b exp=00", {r0r, r1r}); end
        checks++; if ({rid, rlt, req, rgt, rerr} !== 5'b0) begin errors++; $display("FAIL reset_rsp got=%b exp=00000", {rid, rlt, req, rgt, rerr}); end
        checks++; if ({cl, ce, cg} !== 3'b010) begin errors++; $display("FAIL reset_cascade got=%b exp=010", {cl, ce, cg}); end
        checks++; if ({ca, cb} !== 2'b00) begin errors++; $display("FAIL reset_cmp_ab got=%b exp=00", {ca, cb}); end
        r0v = 1'b0;
        r1v = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_equal();
        run_op(1'b0, 8'hA5, 8'hA5, lat, runs);
        checks++; if (lat !== 9) begin errors++; $display("FAIL equal_latency got=%0d exp=9", lat); end
        checks++; if (runs !== 8) begin errors++; $display("FAIL equal_runs got=%0d exp=8", runs); end
        checks++; if ({o_lt, o_eq, o_gt} !== 3'b010) begin errors++; $display("FAIL equal_result got=%b exp=010", {o_lt, o_eq, o_gt}); end
        checks++; if ({o_id, o_err} !== 2'b00) begin errors++; $display("FAIL equal_id_err got=%b exp=00", {o_id, o_err}); end
        hs();
        @(negedge clk);
        checks++; if ({o_rv, o_busy} !== 2'b00) begin errors++; $display("FAIL equal_after_hs got=%b exp=00", {o_rv, o_busy}); end
    endtask

    task automatic test_msb();
        run_op(1'b1, 8'h7F, 8'h80, lat, runs);
        checks++; if (runs !== 1) begin errors++; $display("FAIL msb_runs got=%0d exp=1", runs); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL msb_latency got=%0d exp=2", lat); end
        checks++; if ({o_lt, o_eq, o_gt} !== 3'b100) begin errors++; $display("FAIL msb_result got=%b exp=100", {o_lt, o_eq, o_gt}); end
        checks++; if ({o_id, o_err} !== 2'b10) begin errors++; $display("FAIL msb_id_err got=%b exp=10", {o_id, o_err}); end
        hs();
    endtask

    task automatic test_msb_no_early_exit();
        inst = 1'b1;
        run_op(1'b1, 8'h7F, 8'h80, lat, runs);
        checks++; if (runs !== 8) begin errors++; $display("FAIL full_runs got=%0d exp=8", runs); end
        checks++; if ({o_lt, o_eq, o_gt} !== 3'b100) begin errors++; $display("FAIL full_result got=%b exp=100", {o_lt, o_eq, o_gt}); end
        checks++; if ({o_id, o_err} !== 2'b10) begin errors++; $display("FAIL full_id_err got=%b exp=10", {o_id, o_err}); end
        hs();
        inst = 1'b0;
    endtask

    task automatic test_round_robin();
        int   n;
        logic exp_id;
        do_reset();
        r0a = 8'h10; r0b = 8'h0F; r1a = 8'h03; r1b = 8'h05;
        r0v = 1'b1;
        r1v = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_id = k[0];
            n = 0;
            #1;
            while (!(r0r || r1r) && n < 40) begin @(negedge clk); #1; n++; end
            checks++; if ({r1r, r0r} !== {exp_id, !exp_id}) begin errors++; $display("FAIL rr_grant%0d got=%b exp=%b", k, {r1r, r0r}, {exp_id, !exp_id}); end
            checks++; if (n !== 0) begin errors++; $display("FAIL rr_grant_wait%0d got=%0d exp=0", k, n); end
            @(negedge clk);
            checks++; if ({r1r, r0r} !== 2'b00) begin errors++; $display("FAIL rr_ready_pulse%0d got=%b exp=00", k, {r1r, r0r}); end
            n = 0;
            while (!rv && n < 40) begin @(negedge clk); n++; end
            checks++; if (rid !== exp_id) begin errors++; $display("FAIL rr_id%0d got=%b exp=%b", k, rid, exp_id); end
            checks++; if ({rlt, req, rgt} !== (exp_id ? 3'b100 : 3'b001)) begin errors++; $display("FAIL rr_result%0d got=%b exp=%b", k, {rlt, req, rgt}, exp_id ? 3'b100 : 3'b001); end
            hs();
            @(negedge clk);
        end
        r0v = 1'b0;
        r1v = 1'b0;
    endtask

    task automatic test_backpressure();
        int n;
        run_op(1'b0, 8'h10, 8'h0F, lat, runs);
        r1a = 8'h03;
        r1b = 8'h05;
        r1v = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if ({rv, rid, rlt, req, rgt, rerr, r1r, busy} !== 8'b1000_1001) begin errors++; $display("FAIL bp_hold%0d got=%b exp=10001001", i, {rv, rid, rlt, req, rgt, rerr, r1r, busy}); end
            @(negedge clk);
        end
        hs();
        checks++; if (r1r !== 1'b1) begin errors++; $display("FAIL bp_next_grant got=%b exp=1", r1r); end
        @(posedge clk);
        #1;
        r1v = 1'b0;
        n = 0;
        while (!rv && n < 40) begin @(negedge clk); n++; end
        checks++; if ({rv, rid, rlt, req, rgt} !== 5'b11100) begin errors++; $display("FAIL bp_second got=%b exp=11100", {rv, rid, rlt, req, rgt}); end
        hs();
    endtask

    task automatic test_reset_mid_run();
        int n;
        @(negedge clk);
        r0a = 8'hA5; r0b = 8'hA5; r0v = 1'b1;
        n = 0;
        #1;
        while (!r0r && n < 40) begin @(negedge clk); #1; n++; end
        @(posedge clk);
        repeat (5) @(negedge clk);
        checks++; if ({ca, cb, cl, ce, cg} !== 5'b00010) begin errors++; $display("FAIL mid_bit3 got=%b exp=00010", {ca, cb, cl, ce, cg}); end
        rst_n = 1'b0;
        #1;
        checks++; if ({busy, rv, r0r, r1r} !== 4'b0000) begin errors++; $display("FAIL mid_reset got=%b exp=0000", {busy, rv, r0r, r1r}); end
        @(negedge clk);
        rst_n = 1'b1;
        r0v = 1'b0;
        run_op(1'b0, 8'h22, 8'h21, lat, runs);
        checks++; if (runs !== 7) begin errors++; $display("FAIL mid_after_runs got=%0d exp=7", runs); end
        checks++; if ({rid, rlt, req, rgt, rerr} !== 5'b00010) begin errors++; $display("FAIL mid_after_rsp got=%b exp=00010", {rid, rlt, req, rgt, rerr}); end
        hs();
    endtask

    task automatic test_fault_slice();
        fault = 1'b1;
        run_op(1'b0, 8'hA5, 8'hA5, lat, runs);
        checks++; if (runs !== 3) begin errors++; $display("FAIL fault_runs got=%0d exp=3", runs); end
        checks++; if ({rerr, rlt, req, rgt} !== 4'b1110) begin errors++; $display("FAIL fault_rsp got=%b exp=1110", {rerr, rlt, req, rgt}); end
        hs();
        fault = 1'b0;
        @(negedge clk);
        checks++; if ({rerr, rv} !== 2'b00) begin errors++; $display("FAIL fault_cleared got=%b exp=00", {rerr, rv}); end
    endtask

    initial begin
        clk = 1'b0; rst_n = 1'b1; rr = 1'b0; inst = 1'b0; fault = 1'b0;
        {r0v, r1v, x0v, x1v} = '0;
        {r0a, r0b, r1a, r1b, x0a, x0b, x1a, x1b} = '0;
        errors = 0; checks = 0;
        #2 rst_n = 1'b0;
        test_reset();
        test_equal();
        test_msb();
        test_msb_no_early_exit();
        test_round_robin();
        test_backpressure();
        test_reset_mid_run();
        test_fault_slice();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
